full_adder: RTL and testbench

Registered ripple-carry adder: sums two WIDTH-bit operands plus a carry-in and returns a WIDTH-bit sum and a carry-out. With WIDTH=1 it is the classic 1-bit full adder used as the arithmetic primitive across the datapath. Wider instances chain 1-bit cells and feed ALU and counter blocks. An optional output register gives a fixed one-cycle latency with a valid flag.

---
 rtl/full_adder_pkg.sv | 17 +
 rtl/full_adder_cell.sv | 19 +
 rtl/full_adder.sv | 85 ++++++++
 tb/tb_full_adder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and reference arithmetic for the full_adder family.
// Latency: n/a (package). Backpressure: n/a.
// add_ref is the golden a + b + cin at MAX_WIDTH+1 bits; callers zero-extend operands.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  // Exact sum with the carry kept in the top bit; operands are zero-extended by the caller.
  function automatic logic [MAX_WIDTH:0] add_ref(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 cin
  );
    return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full-adder cell: s = a ^ b ^ cin, cout = majority-style carry.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH chained 1-bit cells, optional output register with valid flag.
// Latency: 1 cycle when REG_OUT=1, 0 (WIDTH-cell ripple) when REG_OUT=0.
// Backpressure: none; one operand set accepted every cycle, no ready signal.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // Refuse to elaborate outside the supported width range.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH must be in 1..%0d", MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign c[0] = cin;

  // Carry chain runs LSB to MSB through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign carry_d = c[WIDTH];

  logic [MAX_WIDTH:0] rip_full;
  logic [MAX_WIDTH:0] ref_full;

  assign rip_full = (MAX_WIDTH + 1)'({carry_d, sum_d});
  assign ref_full = add_ref(MAX_WIDTH'(a), MAX_WIDTH'(b), cin);

  // Cross-check the ripple chain against the arithmetic reference for known inputs.
  always_comb begin
    if (!$isunknown({a, b, cin})) begin
      assert (rip_full == ref_full);
    end
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid_q;

    // Result loads every cycle; out_valid qualifies it. Reset clears everything in flight.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_q       <= '0;
        carry_q     <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        sum_q       <= sum_d;
        carry_q     <= carry_d;
        out_valid_q <= in_valid;
      end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
  end else begin : g_comb
    assign sum       = sum_d;
    assign carry     = carry_d;
    assign out_valid = in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: 1-bit and 8-bit registered instances plus a 4-bit combinational one.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // WIDTH=1, registered
  logic       rst1_n, a1, b1, cin1, v1;
  logic       sum1, carry1, ov1;
  // WIDTH=8, registered
  logic       rst8_n, cin8, v8;
  logic [7:0] a8, b8, sum8;
  logic       carry8, ov8;
  // WIDTH=4, combinational
  logic       rst4_n, cin4, v4;
  logic [3:0] a4, b4, sum4;
  logic       carry4, ov4;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .cin(cin1), .in_valid(v1),
    .sum(sum1), .carry(carry1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst8_n), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
    .sum(sum8), .carry(carry8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst4_n), .a(a4), .b(b4), .cin(cin4), .in_valid(v4),
    .sum(sum4), .carry(carry4), .out_valid(ov4)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]    tt_sum;
  logic [7:0]    tt_carry;
  logic [2:0]    tt_in;
  logic [MAX_WIDTH:0] exp_full;

  initial begin
    tt_sum   = 8'b1001_0110;  // sum for abc = 7..0
    tt_carry = 8'b1110_1000;  // carry for abc = 7..0

    rst1_n = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b0;
    rst8_n = 1'b0; a8 = '0;   b8 = '0;   cin8 = 1'b0; v8 = 1'b0;
    rst4_n = 1'b0; a4 = '0;   b4 = '0;   cin4 = 1'b0; v4 = 1'b0;

    // Reset holds outputs at zero even with a valid 1+1+1 presented.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    tick();
    @(negedge clk);
    tick();
    chk("w1_rst_sum",   65'(sum1),   65'd0);
    chk("w1_rst_carry", 65'(carry1), 65'd0);
    chk("w1_rst_valid", 65'(ov1),    65'd0);

    // First valid input after release shows up one edge later.
    @(negedge clk);
    rst1_n = 1'b1;
    rst8_n = 1'b1;
    tick();
    chk("w1_rel_sum",   65'(sum1),   65'd1);
    chk("w1_rel_carry", 65'(carry1), 65'd1);
    chk("w1_rel_valid", 65'(ov1),    65'd1);

    // Full 1-bit truth table, one vector per cycle.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tt_in = 3'(k);
      a1 = tt_in[2]; b1 = tt_in[1]; cin1 = tt_in[0]; v1 = 1'b1;
      tick();
      chk($sformatf("w1_tt%0d_sum", k),   65'(sum1),   65'(tt_sum[k]));
      chk($sformatf("w1_tt%0d_carry", k), 65'(carry1), 65'(tt_carry[k]));
      chk($sformatf("w1_tt%0d_valid", k), 65'(ov1),    65'd1);
    end

    // 8-bit wrap cases.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; v8 = 1'b1;
    tick();
    chk("w8_wrap0",       65'({carry8, sum8}), 65'h100);
    chk("w8_wrap0_valid", 65'(ov8),            65'd1);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    tick();
    chk("w8_wrap1",       65'({carry8, sum8}), 65'h1FF);

    // No carry, then an idle cycle drops out_valid.
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0;
    tick();
    chk("w8_nocarry",     65'({carry8, sum8}), 65'h07F);
    chk("w8_nocarry_vld", 65'(ov8),            65'd1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
    tick();
    chk("w8_idle_valid",  65'(ov8),            65'd0);

    // Mid-stream reset: the second of three inputs is discarded.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; v8 = 1'b1;
    tick();
    chk("w8_ms1",         65'({carry8, sum8}), 65'h030);
    chk("w8_ms1_valid",   65'(ov8),            65'd1);
    @(negedge clk);
    a8 = 8'hC0; b8 = 8'h40; cin8 = 1'b1; rst8_n = 1'b0;
    tick();
    chk("w8_ms2_rst",     65'({carry8, sum8}), 65'h000);
    chk("w8_ms2_valid",   65'(ov8),            65'd0);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b1; rst8_n = 1'b1;
    tick();
    chk("w8_ms3",         65'({carry8, sum8}), 65'h004);
    chk("w8_ms3_valid",   65'(ov8),            65'd1);

    // Combinational 4-bit: valid gated by reset, result in the same cycle.
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; v4 = 1'b1;
    #1;
    chk("w4_rst_valid",   65'(ov4),            65'd0);
    rst4_n = 1'b1;
    #1;
    chk("w4_9p8",         65'({carry4, sum4}), 65'h11);
    chk("w4_9p8_valid",   65'(ov4),            65'd1);
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #1;
    chk("w4_wrap",        65'({carry4, sum4}), 65'h10);

    // Randomised vectors against the package reference.
    for (int n = 0; n < 1000; n++) begin
      a4   = 4'($urandom_range(0, 15));
      b4   = 4'($urandom_range(0, 15));
      cin4 = 1'($urandom_range(0, 1));
      #1;
      exp_full = add_ref(64'(a4), 64'(b4), cin4);
      chk($sformatf("w4_rand%0d", n), 65'({carry4, sum4}), exp_full);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
